axi_sram_responder: RTL and testbench
=====================================

Name: axi_sram_responder

Overview:
- AXI4 slave (responder) that terminates the axi4_interface driven by the L2 cache's external bus master, backed by a single-port synchronous SRAM array.
- Used as the on-chip/simulation main memory endpoint for FPGA builds and system benches.
- Accepts one burst at a time: read or write, with INCR and FIXED addressing, byte strobes, and 1 beat/cycle sustained throughput.

Parameters:
- MEM_WORDS, 65536, depth of backing array in AXI_DATA_WIDTH-bit words; power of two.
- BASE_ADDR, 32'h0, byte address that maps to word 0.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- axi_bus  axi4_interface.slave  -  AXI4 bus. Drives s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rdata[`AXI_DATA_WIDTH-1:0]; samples all m_* signals.

Interface: one clock (clk); reset is asynchronous and active-high (reset). All state is in flops on posedge clk, cleared on posedge reset.

Behaviour:
- Beat width B = `AXI_DATA_WIDTH/8 bytes.
- Word index = ((addr - BASE_ADDR) >> log2(B)) mod MEM_WORDS; out-of-range addresses wrap.
- m_awsize/m_arsize are treated as full-width regardless of value. m_awcache/m_arcache are ignored.
- FSM states: IDLE, READ_BURST, WRITE_BURST, WRITE_RESP.
- IDLE:
  - s_awready = s_arready = 1; all other outputs 0.
  - If m_awvalid: accept AW. Latch address, beat counter = m_awlen, burst type. Go to WRITE_BURST. Writes win if both m_awvalid and m_arvalid are asserted in the same cycle; AR stays pending.
  - Else if m_arvalid: accept AR. Latch address, counter = m_arlen. Issue SRAM read of the first word. Go to READ_BURST.
- READ_BURST:
  - s_rvalid = 1 starting the cycle after AR acceptance. First-beat latency is 1 cycle.
  - s_rdata is held stable while m_rready = 0.
  - On a beat handshake (s_rvalid & m_rready): if counter == 0, go to IDLE (s_rvalid drops next cycle). Otherwise decrement counter, advance address, and read the next word in the same cycle so the next beat is valid the following cycle (no bubbles).
- WRITE_BURST:
  - s_wready = 1.
  - On each handshake (m_wvalid & s_wready): write the bytes enabled by m_wstrb, leaving other bytes unchanged.
  - If counter == 0, go to WRITE_RESP; otherwise decrement counter and advance address.
  - The burst length comes from m_awlen. m_wlast is not used for termination; a simulation assertion flags m_wlast mismatching counter == 0.
- WRITE_RESP: s_bvalid = 1 until m_bready is sampled high, then go to IDLE. The accepted burst is fully written before s_bvalid rises.
- Address advance:
  - AXI_BURST_FIXED: address unchanged.
  - AXI_BURST_INCR: address += B.
  - AXI_BURST_WRAP: treated as INCR (unsupported).
  - 8-bit counter gives 1..256 beats; word index wraps mod MEM_WORDS.
- Reset (asserted at any time, including mid-burst):
  - State goes to IDLE; s_rvalid, s_bvalid, s_wready go to 0; s_awready, s_arready go to 0 while reset is high; s_rdata goes to 0.
  - The aborted burst produces no further beats or response.
  - SRAM contents are not reset.
- Read-after-write: a read accepted after s_bvalid returns the new data.

Optional Feature:
- Macro: AXI_SRAM_BACKPRESSURE_EN.
- When defined:
  - A 16-bit LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) steps every cycle.
  - When lfsr[0] == 0, s_wready is forced to 0.
  - When lfsr[0] == 0, the next read beat is withheld: s_rvalid is not raised after a handshake. An already-presented beat stays valid.
  - AW/AR acceptance is delayed the same way.
  - Purpose: exercises master stall handling.
- When undefined: no LFSR logic, full throughput as above.

Test Plan:
- Single write then read: AW addr 0x100, awlen 0, wdata 0xDEADBEEF, wstrb all ones, then AR 0x100 arlen 0 -> bvalid once, then rvalid one cycle after AR with rdata 0xDEADBEEF.
- INCR burst: write 16 beats from 0x1000 with data 0..15, then read 16 beats with m_rready held high -> 16 consecutive rvalid cycles with data 0..15, no gaps.
- Strobes and FIXED: fill 0x200 with 0xFFFFFFFF, then write 0x12345678 with wstrb 4'b0101 -> read returns 0xFF34FF78. A FIXED 4-beat write to 0x300 leaves the last beat's data at 0x300 and neighbours untouched.
- Simultaneous AW and AR valid in IDLE -> AW accepted first, AR accepted the cycle after bvalid/bready completes. Read returns the post-write data.
- Backpressure: m_rready toggled 1,0,0,1 during a 4-beat read -> rdata held stable while stalled, exactly 4 handshakes in order. Stalling m_bready for 5 cycles keeps s_bvalid high.
- Reset mid-burst: assert reset after beat 2 of an 8-beat read -> s_rvalid goes to 0 immediately. After deassert, s_awready/s_arready = 1 and a new read of the same address returns the correct data.

Source files
------------

// File: rtl/axi_sram_responder_if.sv
// AXI4 bus bundle shared by the L2 external master and the SRAM responder.
// Only the channels the responder uses are carried (no IDs, no response codes).
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif

interface axi4_interface;
   // Write address channel
   logic                            m_awvalid;
   logic [31:0]                     m_awaddr;
   logic [7:0]                      m_awlen;
   logic [2:0]                      m_awsize;
   logic [1:0]                      m_awburst;
   logic [3:0]                      m_awcache;
   logic                            s_awready;
   // Write data channel
   logic                            m_wvalid;
   logic [`AXI_DATA_WIDTH-1:0]      m_wdata;
   logic [`AXI_DATA_WIDTH/8-1:0]    m_wstrb;
   logic                            m_wlast;
   logic                            s_wready;
   // Write response channel
   logic                            s_bvalid;
   logic                            m_bready;
   // Read address channel
   logic                            m_arvalid;
   logic [31:0]                     m_araddr;
   logic [7:0]                      m_arlen;
   logic [2:0]                      m_arsize;
   logic [1:0]                      m_arburst;
   logic [3:0]                      m_arcache;
   logic                            s_arready;
   // Read data channel
   logic                            s_rvalid;
   logic [`AXI_DATA_WIDTH-1:0]      s_rdata;
   logic                            m_rready;

   modport master (
      output m_awvalid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awcache,
      output m_wvalid, m_wdata, m_wstrb, m_wlast,
      output m_bready,
      output m_arvalid, m_araddr, m_arlen, m_arsize, m_arburst, m_arcache,
      output m_rready,
      input  s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rdata
   );

   modport slave (
      input  m_awvalid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awcache,
      input  m_wvalid, m_wdata, m_wstrb, m_wlast,
      input  m_bready,
      input  m_arvalid, m_araddr, m_arlen, m_arsize, m_arburst, m_arcache,
      input  m_rready,
      output s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rdata
   );
endinterface

// File: rtl/axi_sram_responder.sv
// AXI4 responder backed by a single-port synchronous SRAM. Serves one burst at a
// time (read or write), INCR/FIXED addressing (WRAP behaves as INCR), byte
// strobes, one beat per cycle. Optional master-stall exerciser enabled by
// defining AXI_SRAM_BACKPRESSURE_EN.
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif

module axi_sram_responder #(
   parameter int unsigned MEM_WORDS = 65536,
   parameter logic [31:0] BASE_ADDR = 32'h0
) (
   input  logic         clk,
   input  logic         reset,
   axi4_interface.slave axi_bus
);
   localparam int          DW          = `AXI_DATA_WIDTH;
   localparam int          B           = DW / 8;
   localparam int          LG_B        = $clog2(B);
   localparam int          IDX_W       = $clog2(MEM_WORDS);
   localparam logic [31:0] BEAT_BYTES  = 32'(B);
   localparam logic [1:0]  BURST_FIXED = 2'b00;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ_BURST,
      ST_WRITE_BURST,
      ST_WRITE_RESP
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [31:0]     r_addr;
   logic [7:0]      r_cnt;
   logic [1:0]      r_burst;
   logic [DW-1:0]   r_rdata;
   logic            r_rvalid;
   logic [DW-1:0]   r_mem [MEM_WORDS];

   logic            w_go;
   logic            w_last;
   logic            w_awready, w_arready, w_wready, w_bvalid, w_rvalid;
   logic            w_aw_acc, w_ar_acc, w_w_hs, w_r_hs;
   logic [31:0]     w_addr_nxt;
   logic [31:0]     w_rd_addr;
   logic            w_unused_ok;

   // Byte address -> word index; addresses beyond the array wrap around.
   function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
      return IDX_W'((a - BASE_ADDR) >> LG_B);
   endfunction

`ifdef AXI_SRAM_BACKPRESSURE_EN
   logic [15:0] r_lfsr;

   // Free-running x^16+x^14+x^13+x^11+1 LFSR; bit 0 low stalls the responder.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_lfsr <= 16'hACE1;
      else       r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
   end

   assign w_go = r_lfsr[0];
`else
   assign w_go = 1'b1;
`endif

   assign w_last     = (r_cnt == 8'd0);
   assign w_addr_nxt = (r_burst == BURST_FIXED) ? r_addr : r_addr + BEAT_BYTES;

   // State register.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state and channel ready/valid outputs.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      w_state_nxt = r_state;
      w_awready   = 1'b0;
      w_arready   = 1'b0;
      w_wready    = 1'b0;
      w_bvalid    = 1'b0;
      w_rvalid    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_awready = w_go & ~reset;
            // A pending AW takes priority; AR ready is withheld so the read
            // stays pending instead of completing a handshake we would drop.
            w_arready = w_go & ~reset & ~axi_bus.m_awvalid;
            if (axi_bus.m_awvalid & w_awready)      w_state_nxt = ST_WRITE_BURST;
            else if (axi_bus.m_arvalid & w_arready) w_state_nxt = ST_READ_BURST;
         end
         ST_READ_BURST: begin
            w_rvalid = r_rvalid;
            if (w_rvalid & axi_bus.m_rready & w_last) w_state_nxt = ST_IDLE;
         end
         ST_WRITE_BURST: begin
            w_wready = w_go;
            if (axi_bus.m_wvalid & w_wready & w_last) w_state_nxt = ST_WRITE_RESP;
         end
         ST_WRITE_RESP: begin
            w_bvalid = 1'b1;
            if (axi_bus.m_bready) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign w_aw_acc  = axi_bus.m_awvalid & w_awready;
   assign w_ar_acc  = axi_bus.m_arvalid & w_arready;
   assign w_w_hs    = axi_bus.m_wvalid  & w_wready;
   assign w_r_hs    = w_rvalid & axi_bus.m_rready;
   assign w_rd_addr = w_ar_acc ? axi_bus.m_araddr : w_addr_nxt;

   // Burst address/counter tracking and the registered SRAM read port.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_addr   <= '0;
         r_cnt    <= '0;
         r_burst  <= '0;
         r_rdata  <= '0;
         r_rvalid <= 1'b0;
      end else if (w_aw_acc) begin
         r_addr  <= axi_bus.m_awaddr;
         r_cnt   <= axi_bus.m_awlen;
         r_burst <= axi_bus.m_awburst;
      end else if (w_ar_acc) begin
         r_addr   <= axi_bus.m_araddr;
         r_cnt    <= axi_bus.m_arlen;
         r_burst  <= axi_bus.m_arburst;
         r_rdata  <= r_mem[word_idx(w_rd_addr)];
         r_rvalid <= 1'b1;
      end else if (w_r_hs) begin
         if (w_last) begin
            r_rvalid <= 1'b0;
         end else begin
            // Fetch the next word on the handshake itself so beats run back to back.
            r_cnt    <= r_cnt - 8'd1;
            r_addr   <= w_addr_nxt;
            r_rdata  <= r_mem[word_idx(w_rd_addr)];
            r_rvalid <= w_go;
         end
      end else if ((r_state == ST_READ_BURST) && !r_rvalid) begin
         r_rvalid <= w_go;
      end else if (w_w_hs && !w_last) begin
         r_cnt  <= r_cnt - 8'd1;
         r_addr <= w_addr_nxt;
      end
   end

   // Strobed write into the array on each W handshake.
   // NOTE: the SRAM array is deliberately not reset; its contents survive reset.
   always_ff @(posedge clk) begin
      if (w_w_hs) begin
         for (int b = 0; b < B; b++) begin
            if (axi_bus.m_wstrb[b])
               r_mem[word_idx(r_addr)][b*8 +: 8] <= axi_bus.m_wdata[b*8 +: 8];
         end
      end
   end

   assign axi_bus.s_awready = w_awready;
   assign axi_bus.s_arready = w_arready;
   assign axi_bus.s_wready  = w_wready;
   assign axi_bus.s_bvalid  = w_bvalid;
   assign axi_bus.s_rvalid  = w_rvalid;
   assign axi_bus.s_rdata   = r_rdata;

   // Size and cache attributes are ignored: every beat is full width.
   assign w_unused_ok = ^{axi_bus.m_awsize, axi_bus.m_arsize,
                          axi_bus.m_awcache, axi_bus.m_arcache};

   // Burst length comes from AWLEN; WLAST must agree with it.
   a_wlast_matches_len: assert property (@(posedge clk) disable iff (reset)
      w_w_hs |-> (axi_bus.m_wlast == w_last));

endmodule

// File: tb/tb_axi_sram_responder.sv
// Directed bench for axi_sram_responder (default build): single beat, INCR and
// FIXED bursts, strobes, AW/AR collision, R/B stalls, address wrap, reset mid-burst.
module tb_axi_sram_responder;
   localparam logic [1:0] BT_FIXED = 2'b00;
   localparam logic [1:0] BT_INCR  = 2'b01;
   localparam int         BUDGET   = 64;

   logic clk = 1'b0;
   logic reset;

   int n_total = 0;
   int n_bad   = 0;

   logic [31:0] wr_d  [16];
   logic [31:0] exp_d [16];

   axi4_interface bus ();

   axi_sram_responder #(
      .MEM_WORDS (65536),
      .BASE_ADDR (32'h0)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .axi_bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic do_aw(input logic [31:0] a, input logic [7:0] len, input logic [1:0] bt);
      int cyc;
      bus.m_awaddr  = a;
      bus.m_awlen   = len;
      bus.m_awburst = bt;
      bus.m_awvalid = 1'b1;
      #1;
      cyc = 0;
      while (bus.s_awready !== 1'b1 && cyc < BUDGET) begin
         @(posedge clk); #1; cyc++;
      end
      check("aw_ready", 32'(bus.s_awready), 32'd1);
      @(posedge clk); #1;
      bus.m_awvalid = 1'b0;
   endtask

   task automatic do_ar(input logic [31:0] a, input logic [7:0] len, input logic [1:0] bt);
      int cyc;
      bus.m_araddr  = a;
      bus.m_arlen   = len;
      bus.m_arburst = bt;
      bus.m_arvalid = 1'b1;
      #1;
      cyc = 0;
      while (bus.s_arready !== 1'b1 && cyc < BUDGET) begin
         @(posedge clk); #1; cyc++;
      end
      check("ar_ready", 32'(bus.s_arready), 32'd1);
      @(posedge clk); #1;
      bus.m_arvalid = 1'b0;
   endtask

   // Write nbeats words from wr_d, holding bready low for bstall cycles.
   task automatic do_write(input logic [31:0] a, input int nbeats, input logic [1:0] bt,
                           input logic [3:0] strb, input int bstall);
      int cyc;
      do_aw(a, 8'(nbeats - 1), bt);
      for (int i = 0; i < nbeats; i++) begin
         bus.m_wdata  = wr_d[i];
         bus.m_wstrb  = strb;
         bus.m_wlast  = (i == nbeats - 1);
         bus.m_wvalid = 1'b1;
         #1;
         cyc = 0;
         while (bus.s_wready !== 1'b1 && cyc < BUDGET) begin
            @(posedge clk); #1; cyc++;
         end
         check("w_ready", 32'(bus.s_wready), 32'd1);
         @(posedge clk); #1;
      end
      bus.m_wvalid = 1'b0;
      bus.m_wlast  = 1'b0;
      check("b_valid_up", 32'(bus.s_bvalid), 32'd1);
      for (int s = 0; s < bstall; s++) begin
         @(posedge clk); #1;
         check("b_valid_hold", 32'(bus.s_bvalid), 32'd1);
      end
      bus.m_bready = 1'b1;
      @(posedge clk); #1;
      bus.m_bready = 1'b0;
      #1;
      check("b_valid_once", 32'(bus.s_bvalid), 32'd0);
   endtask

   // Read nbeats words and compare with exp_d; rready follows rr_pat[cycle % 4].
   task automatic do_read(input logic [31:0] a, input int nbeats, input logic [1:0] bt,
                          input logic [3:0] rr_pat);
      int cyc;
      int got;
      do_ar(a, 8'(nbeats - 1), bt);
      check("r_first_latency", 32'(bus.s_rvalid), 32'd1);
      got = 0;
      cyc = 0;
      while (got < nbeats && cyc < BUDGET) begin
         bus.m_rready = rr_pat[cyc % 4];
         check("r_valid", 32'(bus.s_rvalid), 32'd1);
         check("r_data", bus.s_rdata, exp_d[got]);
         if (rr_pat[cyc % 4]) got++;
         @(posedge clk); #1;
         cyc++;
      end
      bus.m_rready = 1'b0;
      check("r_beats", 32'(got), 32'(nbeats));
      check("r_valid_end", 32'(bus.s_rvalid), 32'd0);
   endtask

   initial begin
      reset         = 1'b1;
      bus.m_awvalid = 1'b0; bus.m_awaddr = '0; bus.m_awlen = '0; bus.m_awsize = 3'd2;
      bus.m_awburst = BT_INCR; bus.m_awcache = '0;
      bus.m_wvalid  = 1'b0; bus.m_wdata = '0; bus.m_wstrb = '0; bus.m_wlast = 1'b0;
      bus.m_bready  = 1'b0;
      bus.m_arvalid = 1'b0; bus.m_araddr = '0; bus.m_arlen = '0; bus.m_arsize = 3'd2;
      bus.m_arburst = BT_INCR; bus.m_arcache = '0;
      bus.m_rready  = 1'b0;

      // Reset state
      #2;
      check("rst_awready", 32'(bus.s_awready), 32'd0);
      check("rst_arready", 32'(bus.s_arready), 32'd0);
      check("rst_wready",  32'(bus.s_wready),  32'd0);
      check("rst_bvalid",  32'(bus.s_bvalid),  32'd0);
      check("rst_rvalid",  32'(bus.s_rvalid),  32'd0);
      check("rst_rdata",   bus.s_rdata,        32'h0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      check("idle_awready", 32'(bus.s_awready), 32'd1);
      check("idle_arready", 32'(bus.s_arready), 32'd1);

      // Single write then read
      wr_d[0] = 32'hDEADBEEF;
      do_write(32'h100, 1, BT_INCR, 4'hF, 0);
      exp_d[0] = 32'hDEADBEEF;
      do_read(32'h100, 1, BT_INCR, 4'hF);

      // 16-beat INCR burst, data 0..15, back-to-back read
      for (int i = 0; i < 16; i++) begin
         wr_d[i]  = 32'(i);
         exp_d[i] = 32'(i);
      end
      do_write(32'h1000, 16, BT_INCR, 4'hF, 0);
      do_read(32'h1000, 16, BT_INCR, 4'hF);

      // Byte strobes: lanes 0 and 2 only
      wr_d[0] = 32'hFFFFFFFF;
      do_write(32'h200, 1, BT_INCR, 4'hF, 0);
      wr_d[0] = 32'h12345678;
      do_write(32'h200, 1, BT_INCR, 4'b0101, 0);
      exp_d[0] = 32'hFF34FF78;
      do_read(32'h200, 1, BT_INCR, 4'hF);

      // FIXED write: only the last beat lands at 0x300, neighbours untouched
      wr_d[0] = 32'hAAAA0000; wr_d[1] = 32'hAAAA0001; wr_d[2] = 32'hAAAA0002;
      do_write(32'h2FC, 3, BT_INCR, 4'hF, 0);
      wr_d[0] = 32'h11; wr_d[1] = 32'h22; wr_d[2] = 32'h33; wr_d[3] = 32'h44;
      do_write(32'h300, 4, BT_FIXED, 4'hF, 0);
      exp_d[0] = 32'hAAAA0000; exp_d[1] = 32'h44; exp_d[2] = 32'hAAAA0002;
      do_read(32'h2FC, 3, BT_INCR, 4'hF);
      exp_d[0] = 32'h44; exp_d[1] = 32'h44;
      do_read(32'h300, 2, BT_FIXED, 4'hF);

      // AW and AR together: write first, AR the cycle after the B handshake
      bus.m_awaddr = 32'h400; bus.m_awlen = 8'd0; bus.m_awburst = BT_INCR; bus.m_awvalid = 1'b1;
      bus.m_araddr = 32'h400; bus.m_arlen = 8'd0; bus.m_arburst = BT_INCR; bus.m_arvalid = 1'b1;
      #1;
      check("both_awready", 32'(bus.s_awready), 32'd1);
      check("both_arready_held", 32'(bus.s_arready), 32'd0);
      @(posedge clk); #1;
      bus.m_awvalid = 1'b0;
      bus.m_wdata = 32'hCAFEF00D; bus.m_wstrb = 4'hF; bus.m_wlast = 1'b1; bus.m_wvalid = 1'b1;
      #1;
      check("both_wready", 32'(bus.s_wready), 32'd1);
      check("both_arready_wr", 32'(bus.s_arready), 32'd0);
      @(posedge clk); #1;
      bus.m_wvalid = 1'b0; bus.m_wlast = 1'b0;
      check("both_bvalid", 32'(bus.s_bvalid), 32'd1);
      check("both_arready_b", 32'(bus.s_arready), 32'd0);
      bus.m_bready = 1'b1;
      @(posedge clk); #1;
      bus.m_bready = 1'b0;
      #1;
      check("both_ar_after_b", 32'(bus.s_arready), 32'd1);
      @(posedge clk); #1;
      bus.m_arvalid = 1'b0;
      check("both_rvalid", 32'(bus.s_rvalid), 32'd1);
      check("both_rdata", bus.s_rdata, 32'hCAFEF00D);
      bus.m_rready = 1'b1;
      @(posedge clk); #1;
      bus.m_rready = 1'b0;
      check("both_rvalid_end", 32'(bus.s_rvalid), 32'd0);

      // R backpressure 1,0,0,1 on a 4-beat read; B held off for 5 cycles
      for (int i = 0; i < 4; i++) exp_d[i] = 32'(i);
      do_read(32'h1000, 4, BT_INCR, 4'b1001);
      wr_d[0] = 32'h5A5A0001; wr_d[1] = 32'h5A5A0002;
      do_write(32'h500, 2, BT_INCR, 4'hF, 5);
      exp_d[0] = 32'h5A5A0001; exp_d[1] = 32'h5A5A0002;
      do_read(32'h500, 2, BT_INCR, 4'hF);

      // Address beyond the array wraps: 0x40100 aliases word 0x40 (0x100)
      wr_d[0] = 32'h0BADF00D;
      do_write(32'h0004_0100, 1, BT_INCR, 4'hF, 0);
      exp_d[0] = 32'h0BADF00D;
      do_read(32'h100, 1, BT_INCR, 4'hF);

      // Reset after two beats of an 8-beat read
      do_ar(32'h1000, 8'd7, BT_INCR);
      bus.m_rready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         check("rst_burst_data", bus.s_rdata, 32'(i));
         @(posedge clk); #1;
      end
      bus.m_rready = 1'b0;
      reset = 1'b1;
      #1;
      check("rst_mid_rvalid",  32'(bus.s_rvalid),  32'd0);
      check("rst_mid_rdata",   bus.s_rdata,        32'h0);
      check("rst_mid_awready", 32'(bus.s_awready), 32'd0);
      check("rst_mid_arready", 32'(bus.s_arready), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      check("post_rst_awready", 32'(bus.s_awready), 32'd1);
      check("post_rst_arready", 32'(bus.s_arready), 32'd1);
      check("post_rst_rvalid",  32'(bus.s_rvalid),  32'd0);
      check("post_rst_bvalid",  32'(bus.s_bvalid),  32'd0);
      @(posedge clk); #1;
      check("post_rst_no_beat", 32'(bus.s_rvalid), 32'd0);
      for (int i = 0; i < 8; i++) exp_d[i] = 32'(i);
      do_read(32'h1000, 8, BT_INCR, 4'hF);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
